// File: rtl/seq_mult_param_pkg.sv
// seq_mult_param_pkg: shared FSM state encoding and width helper for the sequential multiplier
//   state_t : IDLE -> RUN -> FIN
//   clog2   : bits needed to hold values 0..n-1
package seq_mult_param_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_mult_sign_adj.sv
// seq_mult_sign_adj: conditional two's-complement negate, used as abs on operands and sign restore on the product
//   i_val : value to adjust
//   i_neg : 1 negates i_val, 0 passes it through
//   o_val : adjusted value (same width)
module seq_mult_sign_adj #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: WIDTH x WIDTH shift-add multiplier, one step per clock, start/busy/done handshake
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : request, accepted only while busy is low
//   is_signed    : two's-complement operands (ignored when SIGNED_EN=0), sampled with start
//   a, b         : multiplicand / multiplier, sampled with start
//   product      : 2*WIDTH result, held until the next completion or reset
//   busy         : high from the accept edge until the completion edge
//   done         : one-cycle pulse in the cycle product updates
module seq_mult_param
  import seq_mult_param_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;
  state_t           r_state, w_state_nxt;
  logic [PW:0]      r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt, w_a_mag, w_b_mag;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_neg, w_neg_nxt, w_neg_op;
  logic             r_done, w_done_nxt;
  logic [PW-1:0]    r_prod, w_prod_nxt, w_prod_adj;
  logic [WIDTH:0]   w_hi;
  if (SIGNED_EN) begin : g_sgn
    seq_mult_sign_adj #(.W(WIDTH)) u_abs_a (
      .i_val(a),
      .i_neg(is_signed & a[WIDTH-1]),
      .o_val(w_a_mag)
    );
    seq_mult_sign_adj #(.W(WIDTH)) u_abs_b (
      .i_val(b),
      .i_neg(is_signed & b[WIDTH-1]),
      .o_val(w_b_mag)
    );
    seq_mult_sign_adj #(.W(PW)) u_neg_p (
      .i_val(r_acc[PW-1:0]),
      .i_neg(r_neg),
      .o_val(w_prod_adj)
    );
    assign w_neg_op = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end else begin : g_uns
    logic w_unused;
    assign w_unused   = is_signed | r_neg;
    assign w_a_mag    = a;
    assign w_b_mag    = b;
    assign w_prod_adj = r_acc[PW-1:0];
    assign w_neg_op   = 1'b0;
  end
  // acc[PW] is always 0 before the add, so the full top slice doubles as the WIDTH+1 bit sum input
  assign w_hi = r_acc[PW:WIDTH] + (r_acc[0] ? {1'b0, r_a} : '0);
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_a_nxt     = r_a;
    w_cnt_nxt   = r_cnt;
    w_neg_nxt   = r_neg;
    w_prod_nxt  = r_prod;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_RUN;
        w_acc_nxt   = {{(WIDTH + 1){1'b0}}, w_b_mag};
        w_a_nxt     = w_a_mag;
        w_neg_nxt   = w_neg_op;
        w_cnt_nxt   = '0;
      end
      ST_RUN: begin
        w_acc_nxt   = {w_hi, r_acc[WIDTH-1:0]} >> 1;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = (r_cnt == CW'(WIDTH - 1)) ? ST_FIN : ST_RUN;
      end
      ST_FIN: begin
        w_prod_nxt  = w_prod_adj;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_prod  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_a     <= w_a_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg   <= w_neg_nxt;
      r_prod  <= w_prod_nxt;
      r_done  <= w_done_nxt;
    end
  end
  assign product = r_prod;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed checks of the 8-bit sequential multiplier, signed and unsigned builds
module tb_seq_mult_param;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] product, product_u;
  logic        busy, done, busy_u, done_u;
  int          vectors = 0;
  int          miscompares = 0;
  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .product(product), .busy(busy), .done(done)
  );
  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .product(product_u), .busy(busy_u), .done(done_u)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic sg, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp);
    int lat;
    @(negedge clk);
    start = 1'b1; is_signed = sg; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; is_signed = ~sg; a = ~av; b = bv + 8'd1;
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " product"}, 32'(product), 32'(exp));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " product_held"}, 32'(product), 32'(exp));
  endtask
  initial begin
    #12;
    chk("reset product", 32'(product), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy_u", 32'(busy_u), 32'd0);
    chk("reset done_u", 32'(done_u), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op("s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run_op("s-3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run_op("u253x5", 1'b0, 8'hFD, 8'h05, 16'h04F1);
    run_op("u0x200", 1'b0, 8'h00, 8'hC8, 16'h0000);
    run_op("u200x0", 1'b0, 8'hC8, 8'h00, 16'h0000);
    run_op("s127x-1", 1'b1, 8'h7F, 8'hFF, 16'hFF81);
    // continuous start: only the operands at each accept edge matter
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'd7; b = 8'd9;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      a = 8'(8'h11 * (i + 1)); b = 8'(8'hF0 - i); is_signed = i[0];
      @(negedge clk);
    end
    chk("b2b op1 done", 32'(done), 32'd1);
    chk("b2b op1 product", 32'(product), 32'h003F);
    a = 8'hFE; b = 8'd100; is_signed = 1'b1;
    @(negedge clk);
    chk("b2b op2 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      a = 8'(8'h23 + i); b = 8'(8'h81 + i); is_signed = ~i[0];
      @(negedge clk);
    end
    chk("b2b op2 done", 32'(done), 32'd1);
    chk("b2b op2 product", 32'(product), 32'hFF38);
    start = 1'b0;
    // async reset in the middle of a run
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", 32'(busy), 32'd1);
    chk("abort product_held", 32'(product), 32'hFF38);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort product", 32'(product), 32'd0);
    @(negedge clk);
    chk("abort no_done", 32'(done), 32'd0);
    reset = 1'b0;
    run_op("after_reset 12x13", 1'b0, 8'd12, 8'd13, 16'h009C);
    run_op("s-1x2", 1'b1, 8'hFF, 8'h02, 16'hFFFE);
    chk("nosign FFx02 product", 32'(product_u), 32'h01FE);
    chk("nosign busy", 32'(busy_u), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
